// File: rtl/ppg_fir_pkg.sv
// Shared constants and types for the time-multiplexed PPG FIR scheduler.
// Symmetric 22-tap filter; only the 11 unique coefficients are stored.
package ppg_fir_pkg;

    localparam int unsigned FIR_TAPS      = 22;
    localparam int unsigned FIR_HALF_TAPS = 11;
    localparam int unsigned COEFF_W       = 8;

    localparam logic [COEFF_W-1:0] FIR_COEFF [FIR_HALF_TAPS] = '{
        8'd2, 8'd10, 8'd16, 8'd28, 8'd43, 8'd60,
        8'd78, 8'd95, 8'd111, 8'd122, 8'd128
    };

    localparam logic CH_IR  = 1'b0;
    localparam logic CH_RED = 1'b1;

    typedef enum logic {IDLE, MAC} fir_state_t;

endpackage

// File: rtl/ppg_fir_scheduler_if.sv
// Sample handshakes and filtered-result bus of the PPG FIR scheduler.
// master = sample source / result sink, slave = scheduler.
interface ppg_fir_scheduler_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
);
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir_data;
    logic              red_valid;
    logic              red_ready;
    logic [DATA_W-1:0] red_data;
    logic              out_valid;
    logic              out_chan;
    logic [ACC_W-1:0]  out_data;
    logic [ACC_W-1:0]  ir_filtered;
    logic [ACC_W-1:0]  red_filtered;
    logic              busy;

    modport master (
        output ir_valid, ir_data, red_valid, red_data,
        input  ir_ready, red_ready, out_valid, out_chan, out_data,
               ir_filtered, red_filtered, busy
    );

    modport slave (
        input  ir_valid, ir_data, red_valid, red_data,
        output ir_ready, red_ready, out_valid, out_chan, out_data,
               ir_filtered, red_filtered, busy
    );
endinterface

// File: rtl/ppg_fir_history.sv
// 22-deep per-channel sample history with shift enable, sync clear and a
// folded read port returning h[tap] and h[21-tap].
module ppg_fir_history
    import ppg_fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK_Filter,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    input  logic [3:0]        i_tap,
    output logic [DATA_W-1:0] o_near,
    output logic [DATA_W-1:0] o_far
);
    logic [DATA_W-1:0] r_h [FIR_TAPS];
    logic [4:0]        w_near_idx;
    logic [4:0]        w_far_idx;

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '{default: '0};
        end else if (i_clr) begin
            r_h <= '{default: '0};
        end else if (i_shift) begin
            r_h[0] <= i_data;
            for (int unsigned i = 1; i < FIR_TAPS; i++) begin
                r_h[i] <= r_h[i-1];
            end
        end
    end

    assign w_near_idx = {1'b0, i_tap};
    assign w_far_idx  = 5'(FIR_TAPS - 1) - w_near_idx;
    assign o_near     = r_h[w_near_idx];
    assign o_far      = r_h[w_far_idx];

endmodule

// File: rtl/ppg_fir_scheduler.sv
// Round-robin IR/RED scheduler sharing one folded 22-tap FIR MAC engine.
// Optional macro PPG_FIR_SCHED_NORM_EN: rounded >> NORM_SHIFT on results.
module ppg_fir_scheduler
    import ppg_fir_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 20,
    parameter int unsigned NORM_SHIFT = 10
) (
    input  logic               CLK_Filter,
    input  logic               rst_n,
    input  logic               flush,
    ppg_fir_scheduler_if.slave bus
);
    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned PROD_W = SUM_W + COEFF_W;

    fir_state_t       r_state;
    logic [3:0]       r_tap;
    logic [ACC_W-1:0] r_acc;
    logic             r_chan;
    logic             r_last;
    logic             r_busy;
    logic             r_out_valid;
    logic             r_out_chan;
    logic [ACC_W-1:0] r_out_data;
    logic [ACC_W-1:0] r_ir_filt;
    logic [ACC_W-1:0] r_red_filt;

    logic              w_idle;
    logic              w_grant_ir;
    logic              w_grant_red;
    logic [DATA_W-1:0] w_ir_near, w_ir_far, w_red_near, w_red_far;
    logic [DATA_W-1:0] w_near, w_far;
    logic [SUM_W-1:0]  w_pair;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_result;

    // r_last holds the channel served last; the other one wins a tie.
    assign w_idle      = (r_state == IDLE) && !flush;
    assign w_grant_ir  = w_idle && bus.ir_valid  && (!bus.red_valid || (r_last == CH_RED));
    assign w_grant_red = w_idle && bus.red_valid && (!bus.ir_valid  || (r_last == CH_IR));

    ppg_fir_history #(.DATA_W(DATA_W)) u_hist_ir (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .i_clr      (flush),
        .i_shift    (w_grant_ir),
        .i_data     (bus.ir_data),
        .i_tap      (r_tap),
        .o_near     (w_ir_near),
        .o_far      (w_ir_far)
    );

    ppg_fir_history #(.DATA_W(DATA_W)) u_hist_red (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .i_clr      (flush),
        .i_shift    (w_grant_red),
        .i_data     (bus.red_data),
        .i_tap      (r_tap),
        .o_near     (w_red_near),
        .o_far      (w_red_far)
    );

    assign w_near = (r_chan == CH_RED) ? w_red_near : w_ir_near;
    assign w_far  = (r_chan == CH_RED) ? w_red_far  : w_ir_far;
    assign w_pair = {1'b0, w_near} + {1'b0, w_far};
    assign w_prod = PROD_W'(FIR_COEFF[r_tap]) * PROD_W'(w_pair);
    assign w_sum  = r_acc + ACC_W'(w_prod);

`ifdef PPG_FIR_SCHED_NORM_EN
    localparam logic [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(1) << (NORM_SHIFT - 1);
    logic [ACC_W:0] w_rounded;
    assign w_rounded = {1'b0, w_sum} + ROUND_BIAS;
    assign w_result  = ACC_W'(w_rounded >> NORM_SHIFT);
`else
    assign w_result = w_sum;
`endif

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_acc       <= '0;
            r_chan      <= CH_IR;
            r_last      <= CH_RED;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_chan  <= 1'b0;
            r_out_data  <= '0;
            r_ir_filt   <= '0;
            r_red_filt  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_state <= IDLE;
                r_acc   <= '0;
                r_tap   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_grant_ir || w_grant_red) begin
                            r_chan  <= w_grant_red ? CH_RED : CH_IR;
                            r_last  <= w_grant_red ? CH_RED : CH_IR;
                            r_acc   <= '0;
                            r_tap   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= MAC;
                        end
                    end
                    MAC: begin
                        r_acc <= w_sum;
                        r_tap <= r_tap + 4'd1;
                        if (r_tap == 4'(FIR_HALF_TAPS - 1)) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_chan  <= r_chan;
                            r_out_data  <= w_result;
                            if (r_chan == CH_RED) r_red_filt <= w_result;
                            else                  r_ir_filt  <= w_result;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ir_ready     = w_grant_ir;
    assign bus.red_ready    = w_grant_red;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_chan     = r_out_chan;
    assign bus.out_data     = r_out_data;
    assign bus.ir_filtered  = r_ir_filt;
    assign bus.red_filtered = r_red_filt;
    assign bus.busy         = r_busy;

endmodule
